// File: rtl/multicycle_control.sv
// Moore FSM sequencing the multicycle 64-bit RISC-V datapath (R-type, addi, ld, sd, beq).
// Define CTRL_HALT_ON_ILLEGAL_EN to park the core in HALT on an unrecognised opcode.
module multicycle_control #(
  parameter logic [2:0] ALU_ADD = 3'b000,
  parameter logic [2:0] ALU_SUB = 3'b001,
  parameter logic [2:0] ALU_AND = 3'b010,
  parameter logic [2:0] ALU_OR  = 3'b011,
  parameter logic [2:0] ALU_XOR = 3'b100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        alu_zero,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        PCSource,
  output logic        ALUSrcA,
  output logic        LoadAOut,
  output logic        RegWrite,
  output logic        LoadRegA,
  output logic        LoadRegB,
  output logic        MemToReg,
  output logic        DMemOp,
  output logic        LoadMDR,
  output logic        IMemRead,
  output logic        IRWrite,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  ALUOp,
  output logic        halted
);

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StIrLoad   = 4'd1,
    StDecode   = 4'd2,
    StExecR    = 4'd3,
    StExecI    = 4'd4,
    StAluWb    = 4'd5,
    StMemAddr  = 4'd6,
    StMemRead  = 4'd7,
    StMemLoad  = 4'd8,
    StLdWb     = 4'd9,
    StMemWrite = 4'd10,
    StBranch   = 4'd11,
`ifdef CTRL_HALT_ON_ILLEGAL_EN
    StPcInc    = 4'd12,
    StHalt     = 4'd13
`else
    StPcInc    = 4'd12
`endif
  } state_e;

  state_e state_q, state_d;

  logic [6:0] opcode;
  logic [3:0] r_func;
  logic [2:0] r_alu_op;
  logic       unused_instr;

  assign opcode       = instruction[6:0];
  assign r_func       = {instruction[30], instruction[14:12]};
  assign unused_instr = ^{instruction[31], instruction[29:15], instruction[11:7]};

  always_comb begin
    case (r_func)
      4'b0000: r_alu_op = ALU_ADD;
      4'b1000: r_alu_op = ALU_SUB;
      4'b0111: r_alu_op = ALU_AND;
      4'b0110: r_alu_op = ALU_OR;
      4'b0100: r_alu_op = ALU_XOR;
      default: r_alu_op = ALU_ADD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSource    = 1'b0;
    ALUSrcA     = 1'b0;
    LoadAOut    = 1'b0;
    RegWrite    = 1'b0;
    LoadRegA    = 1'b0;
    LoadRegB    = 1'b0;
    MemToReg    = 1'b0;
    DMemOp      = 1'b0;
    LoadMDR     = 1'b0;
    IMemRead    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = ALU_ADD;
    halted      = 1'b0;

    case (state_q)
      StFetch: begin
        IMemRead = 1'b1;
        state_d  = StIrLoad;
      end
      StIrLoad: begin
        IMemRead = 1'b1;
        IRWrite  = 1'b1;
        state_d  = StDecode;
      end
      StDecode: begin
        // Branch target (PC + imm*2) is parked in ALUOut for BRANCH to use.
        LoadRegA = 1'b1;
        LoadRegB = 1'b1;
        LoadAOut = 1'b1;
        ALUSrcB  = 2'b11;
        case (opcode)
          OpR:              state_d = StExecR;
          OpImm:            state_d = StExecI;
          OpLoad, OpStore:  state_d = StMemAddr;
          OpBranch:         state_d = StBranch;
`ifdef CTRL_HALT_ON_ILLEGAL_EN
          default:          state_d = StHalt;
`else
          default:          state_d = StPcInc;
`endif
        endcase
      end
      StExecR: begin
        ALUSrcA  = 1'b1;
        LoadAOut = 1'b1;
        ALUOp    = r_alu_op;
        state_d  = StAluWb;
      end
      StExecI, StMemAddr: begin
        ALUSrcA  = 1'b1;
        ALUSrcB  = 2'b10;
        LoadAOut = 1'b1;
        if (state_q == StExecI) begin
          state_d = StAluWb;
        end else if (opcode == OpLoad) begin
          state_d = StMemRead;
        end else begin
          state_d = StMemWrite;
        end
      end
      StAluWb: begin
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
        ALUSrcB  = 2'b01;
        state_d  = StFetch;
      end
      StMemRead: begin
        state_d = StMemLoad;
      end
      StMemLoad: begin
        LoadMDR = 1'b1;
        state_d = StLdWb;
      end
      StLdWb: begin
        RegWrite = 1'b1;
        MemToReg = 1'b1;
        PCWrite  = 1'b1;
        ALUSrcB  = 2'b01;
        state_d  = StFetch;
      end
      StMemWrite: begin
        DMemOp  = 1'b1;
        PCWrite = 1'b1;
        ALUSrcB = 2'b01;
        state_d = StFetch;
      end
      StBranch: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALU_SUB;
        PCWriteCond = 1'b1;
        PCSource    = 1'b1;
        state_d     = alu_zero ? StFetch : StPcInc;
      end
      StPcInc: begin
        PCWrite = 1'b1;
        ALUSrcB = 2'b01;
        state_d = StFetch;
      end
`ifdef CTRL_HALT_ON_ILLEGAL_EN
      StHalt: begin
        halted  = 1'b1;
        state_d = StHalt;
      end
`endif
      default: begin
        state_d = StFetch;
      end
    endcase
  end

endmodule
